// File: rtl/tf_ide_pkg.sv
// Shared definitions for the IDE PIO cycle sequencer: state encoding,
// decode base, timing defaults and the counter width.
package tf_ide_pkg;

    localparam int CNT_W          = 4;
    localparam int SETUP_CYC_DEF  = 2;
    localparam int STROBE_CYC_DEF = 4;
    localparam int HOLD_CYC_DEF   = 1;

    // A[23:13] of the IDE window: $DA with A[15:13] = 3'b001
    localparam logic [10:0] IDE_BASE = {8'hDA, 3'b001};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TERM   = 3'd4
    } ide_state_e;

    // Counter preload for a phase lasting cyc clocks; zero is treated as one.
    function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
        if (cyc <= 32'sd1) begin
            cyc_load = {CNT_W{1'b0}};
        end else begin
            cyc_load = CNT_W'(cyc - 32'sd1);
        end
    endfunction

endpackage

// File: rtl/ide_timer.sv
// Loadable down-counter with a zero flag, shared by the SETUP, STROBE and
// HOLD phases of the IDE cycle sequencer.
module ide_timer
    import tf_ide_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (srst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ide_cycle_ctrl.sv
// 68030-side IDE PIO cycle sequencer for the $DA2000-$DA3FFF window.
// Optional macro IDE_IORDY_EN adds the IDE_IORDY wait input.
module ide_cycle_ctrl
    import tf_ide_pkg::*;
#(
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW,
    input  logic [23:0] A,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        DSACK1,
    output logic        ACCESS,
    output logic        IDE_CS0,
    output logic        IDE_CS1,
    output logic [2:0]  IDE_A,
    output logic        IDE_RD,
    output logic        IDE_WR,
    input  logic [15:0] IDE_DIN,
`ifdef IDE_IORDY_EN
    input  logic        IDE_IORDY,
`endif
    output logic [15:0] IDE_DOUT,
    output logic        IDE_DOE
);

    localparam logic [CNT_W-1:0] SETUP_LD  = cyc_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = cyc_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = cyc_load(HOLD_CYC);

    ide_state_e       state_r;
    ide_state_e       state_next_s;
    logic             hit_s;
    logic             iordy_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;
    logic             tmr_srst_s;
    logic             abort_r;
    logic             cs1_r;
    logic             rd_r;
    logic             entry_s;
    logic             cs1_s;
    logic             rd_s;
    logic             cs_act_s;
    logic             capture_s;
    logic             unused_s;

    assign hit_s    = (A[23:13] == IDE_BASE);
    assign ACCESS   = ~hit_s;
    assign unused_s = ^{A[11:5], A[1:0]};

`ifdef IDE_IORDY_EN
    assign iordy_s = IDE_IORDY;
`else
    assign iordy_s = 1'b1;
`endif

    ide_timer u_timer (
        .clk      (CLKCPU),
        .rst_n    (RESET),
        .srst     (tmr_srst_s),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Phase sequencing; the strobe always runs its full count before any abort takes effect.
    always_comb begin
        state_next_s = state_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (!AS20 && hit_s) begin
                    state_next_s = ST_SETUP;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = SETUP_LD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (AS20) begin
                    state_next_s = ST_IDLE;
                end else if (tmr_zero_s) begin
                    state_next_s = ST_STROBE;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = STROBE_LD;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (tmr_zero_s && iordy_s) begin
                    if (abort_r || AS20) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_HOLD;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = HOLD_LD;
                    end
                end else begin
                    state_next_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (AS20) begin
                    state_next_s = ST_IDLE;
                end else if (tmr_zero_s) begin
                    state_next_s = ST_TERM;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_TERM: begin
                if (AS20) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_TERM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so the entry cycle uses the live bus.
    always_comb begin
        entry_s    = 1'b0;
        cs1_s      = cs1_r;
        rd_s       = rd_r;
        cs_act_s   = 1'b0;
        capture_s  = 1'b0;
        tmr_srst_s = (state_next_s == ST_IDLE);
        if ((state_r == ST_IDLE) && (state_next_s == ST_SETUP)) begin
            entry_s = 1'b1;
            cs1_s   = A[12];
            rd_s    = RW;
        end else begin
            entry_s = 1'b0;
        end
        if ((state_next_s == ST_SETUP) || (state_next_s == ST_STROBE) ||
            (state_next_s == ST_HOLD)) begin
            cs_act_s = 1'b1;
        end else begin
            cs_act_s = 1'b0;
        end
        if ((state_r == ST_STROBE) && (state_next_s != ST_STROBE) && rd_r) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // State register plus sticky record of an AS20 release seen mid-strobe.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_STROBE) && (state_next_s == ST_STROBE)) begin
                abort_r <= abort_r | AS20;
            end else begin
                abort_r <= 1'b0;
            end
        end
    end

    // Registered bus outputs and per-cycle latches.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            cs1_r    <= 1'b0;
            rd_r     <= 1'b0;
            IDE_CS0  <= 1'b1;
            IDE_CS1  <= 1'b1;
            IDE_RD   <= 1'b1;
            IDE_WR   <= 1'b1;
            DSACK1   <= 1'b1;
            D_OE     <= 1'b0;
            IDE_DOE  <= 1'b0;
            IDE_A    <= 3'd0;
            IDE_DOUT <= 16'h0000;
            D_OUT    <= 16'h0000;
        end else begin
            cs1_r   <= cs1_s;
            rd_r    <= rd_s;
            IDE_CS0 <= ~(cs_act_s & ~cs1_s);
            IDE_CS1 <= ~(cs_act_s & cs1_s);
            IDE_RD  <= ~((state_next_s == ST_STROBE) & rd_s);
            IDE_WR  <= ~((state_next_s == ST_STROBE) & ~rd_s);
            DSACK1  <= ~(state_next_s == ST_TERM);
            D_OE    <= (state_next_s == ST_TERM) & rd_s & ~DS20;
            IDE_DOE <= cs_act_s & ~rd_s;
            if (entry_s) begin
                IDE_A <= A[4:2];
                if (!RW) begin
                    IDE_DOUT <= D_IN;
                end
            end
            if (capture_s) begin
                D_OUT <= IDE_DIN;
            end
        end
    end

endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// Self-checking bench for ide_cycle_ctrl: directed cases plus randomized
// cycles compared against a phase-timeline model built from the cycle counts.
module tb_ide_cycle_ctrl;

    localparam int S = 2;
    localparam int T = 4;
    localparam int H = 1;

    localparam int PH_IDLE   = 0;
    localparam int PH_SETUP  = 1;
    localparam int PH_STROBE = 2;
    localparam int PH_HOLD   = 3;
    localparam int PH_TERM   = 4;

    logic        CLKCPU = 1'b0;
    logic        RESET;
    logic        AS20;
    logic        DS20;
    logic        RW;
    logic [23:0] A;
    logic [15:0] D_IN;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic        DSACK1;
    logic        ACCESS;
    logic        IDE_CS0;
    logic        IDE_CS1;
    logic [2:0]  IDE_A;
    logic        IDE_RD;
    logic        IDE_WR;
    logic [15:0] IDE_DIN;
    logic [15:0] IDE_DOUT;
    logic        IDE_DOE;
`ifdef IDE_IORDY_EN
    logic        IDE_IORDY;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [2:0]  exp_ia;
    logic [15:0] exp_idout;
    logic [15:0] exp_dout;

    ide_cycle_ctrl dut (
        .CLKCPU   (CLKCPU),
        .RESET    (RESET),
        .AS20     (AS20),
        .DS20     (DS20),
        .RW       (RW),
        .A        (A),
        .D_IN     (D_IN),
        .D_OUT    (D_OUT),
        .D_OE     (D_OE),
        .DSACK1   (DSACK1),
        .ACCESS   (ACCESS),
        .IDE_CS0  (IDE_CS0),
        .IDE_CS1  (IDE_CS1),
        .IDE_A    (IDE_A),
        .IDE_RD   (IDE_RD),
        .IDE_WR   (IDE_WR),
        .IDE_DIN  (IDE_DIN),
`ifdef IDE_IORDY_EN
        .IDE_IORDY(IDE_IORDY),
`endif
        .IDE_DOUT (IDE_DOUT),
        .IDE_DOE  (IDE_DOE)
    );

    always #5 CLKCPU = ~CLKCPU;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Phase after edge m of an uninterrupted cycle with w extra wait clocks.
    function automatic int normal_phase(input int m, input int w);
        if (m < S)             return PH_SETUP;
        if (m < S + T + w)     return PH_STROBE;
        if (m < S + T + w + H) return PH_HOLD;
        return PH_TERM;
    endfunction

    // AS20 is first seen high at edge rel; a strobe in progress still completes.
    function automatic int phase_of(input int n, input int rel, input int w);
        int p;
        if (n < rel) return normal_phase(n, w);
        p = normal_phase(rel - 1, w);
        if (p == PH_STROBE && n < S + T + w) return PH_STROBE;
        return PH_IDLE;
    endfunction

    task automatic check_outputs(input int ph, input logic a12, input logic rw, input logic ds_low);
        logic cs;
        cs = (ph == PH_SETUP) || (ph == PH_STROBE) || (ph == PH_HOLD);
        chk_b("cs0", IDE_CS0, !(cs && !a12));
        chk_b("cs1", IDE_CS1, !(cs && a12));
        chk_b("rd", IDE_RD, !(ph == PH_STROBE && rw));
        chk_b("wr", IDE_WR, !(ph == PH_STROBE && !rw));
        chk_b("dsack1", DSACK1, !(ph == PH_TERM));
        chk_b("ide_doe", IDE_DOE, cs && !rw);
        chk_b("d_oe", D_OE, (ph == PH_TERM) && rw && ds_low);
        chk_w("ide_a", {13'd0, IDE_A}, {13'd0, exp_ia});
        chk_w("ide_dout", IDE_DOUT, exp_idout);
        chk_w("d_out", D_OUT, exp_dout);
    endtask

    task automatic run_hit(input logic [23:0] addr, input logic rw, input logic [15:0] wd,
                           input logic [15:0] rd, input int rel, input int w, input int ds_at);
        int ph;
        int prev_ph;
        int last_n;
        A       = addr;
        RW      = rw;
        D_IN    = wd;
        IDE_DIN = rd;
        AS20    = 1'b0;
        DS20    = (ds_at == 0) ? 1'b0 : 1'b1;
`ifdef IDE_IORDY_EN
        IDE_IORDY = 1'b1;
`endif
        #1;
        chk_b("access_hit", ACCESS, 1'b0);
        exp_ia = addr[4:2];
        if (!rw) exp_idout = wd;
        last_n = rel;
        if (phase_of(rel, rel, w) == PH_STROBE) last_n = S + T + w;
        prev_ph = PH_IDLE;
        for (int n = 0; n <= last_n; n++) begin
            @(posedge CLKCPU);
            #1;
            ph = phase_of(n, rel, w);
            if (rw && prev_ph == PH_STROBE && ph != PH_STROBE) exp_dout = rd;
            check_outputs(ph, addr[12], rw, n >= ds_at);
            prev_ph = ph;
            AS20 = (n + 1 >= rel) ? 1'b1 : 1'b0;
            DS20 = (n + 1 >= rel || n + 1 < ds_at) ? 1'b1 : 1'b0;
`ifdef IDE_IORDY_EN
            IDE_IORDY = ((n + 1) >= S + T && (n + 1) < S + T + w) ? 1'b0 : 1'b1;
`endif
        end
        AS20 = 1'b1;
        DS20 = 1'b1;
`ifdef IDE_IORDY_EN
        IDE_IORDY = 1'b1;
`endif
    endtask

    task automatic run_miss(input logic [23:0] addr, input logic rw);
        A    = addr;
        RW   = rw;
        AS20 = 1'b0;
        DS20 = 1'b0;
        #1;
        chk_b("access_miss", ACCESS, 1'b1);
        for (int n = 0; n < 4; n++) begin
            @(posedge CLKCPU);
            #1;
            check_outputs(PH_IDLE, addr[12], rw, 1'b1);
        end
        AS20 = 1'b1;
        DS20 = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [23:0] addr;
        logic        rw;
        int          rel;
        int          ds_at;

        RESET   = 1'b0;
        AS20    = 1'b1;
        DS20    = 1'b1;
        RW      = 1'b1;
        A       = 24'h000000;
        D_IN    = 16'h0000;
        IDE_DIN = 16'h0000;
`ifdef IDE_IORDY_EN
        IDE_IORDY = 1'b1;
`endif
        exp_ia    = 3'd0;
        exp_idout = 16'h0000;
        exp_dout  = 16'h0000;

        repeat (2) @(posedge CLKCPU);
        #1;
        check_outputs(PH_IDLE, 1'b0, 1'b1, 1'b1);
        RESET = 1'b1;
        @(posedge CLKCPU);
        #1;

        // Test-plan read, write, CS1 read and decode misses.
        run_hit(24'hDA2004, 1'b1, 16'h0000, 16'hA55A, S + T + H + 2, 0, 2);
        run_hit(24'hDA201C, 1'b0, 16'h00EC, 16'h0000, S + T + H + 2, 0, 0);
        run_hit(24'hDA3018, 1'b1, 16'h0000, 16'h5AA5, S + T + H + 1, 0, 0);
        run_miss(24'hDA0000, 1'b1);
        run_miss(24'hDE1000, 1'b0);

        // Abort in the first SETUP cycle, then during STROBE.
        run_hit(24'hDA2008, 1'b1, 16'h0000, 16'h1111, 1, 0, 0);
        run_hit(24'hDA2010, 1'b0, 16'hBEEF, 16'h0000, S + 1, 0, 0);

        // Async reset in the middle of a strobe, then a clean read.
        A    = 24'hDA2004;
        RW   = 1'b1;
        AS20 = 1'b0;
        DS20 = 1'b0;
        IDE_DIN = 16'h7777;
        repeat (4) @(posedge CLKCPU);
        #1;
        chk_b("rd_before_reset", IDE_RD, 1'b0);
        RESET = 1'b0;
        #1;
        exp_ia    = 3'd0;
        exp_idout = 16'h0000;
        exp_dout  = 16'h0000;
        check_outputs(PH_IDLE, 1'b0, 1'b1, 1'b1);
        AS20 = 1'b1;
        DS20 = 1'b1;
        @(posedge CLKCPU);
        #1;
        check_outputs(PH_IDLE, 1'b0, 1'b1, 1'b1);
        RESET = 1'b1;
        run_hit(24'hDA2004, 1'b1, 16'h0000, 16'hC3C3, S + T + H + 1, 0, 0);

`ifdef IDE_IORDY_EN
        run_hit(24'hDA2004, 1'b1, 16'h0000, 16'h2468, S + T + H + 5 + 2, 5, 0);
        run_hit(24'hDA3000, 1'b0, 16'h1357, 16'h0000, S + 2, 3, 0);
`endif

        // Randomized mix of hits, misses, aborts and DS20 timing.
        for (int k = 0; k < 40; k++) begin
            r  = $urandom();
            rw = r[31];
            if (r[30:29] == 2'b00) begin
                addr = r[23:0];
                if (addr[23:13] == {8'hDA, 3'b001}) addr[23:16] = 8'h5A;
                run_miss(addr, rw);
            end else begin
                addr = {8'hDA, 3'b001, r[12:0]};
                if (r[28:27] == 2'b00) begin
                    rel = $urandom_range(1, S + T + H);
                end else begin
                    rel = S + T + H + 1 + $urandom_range(0, 2);
                end
                ds_at = $urandom_range(0, S + T + H + 1);
                r = $urandom();
                run_hit(addr, rw, r[31:16], r[15:0], rel, 0, ds_at);
            end
            @(posedge CLKCPU);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ide_cycle_ctrl.md
Name: ide_cycle_ctrl

Overview:
- 68030-side IDE PIO cycle sequencer for the Gayle-compatible IDE window at $DA2000–$DA3FFF.
- Decodes the task-file and alternate-status spaces, then sequences chip-select, address, strobe and data-latch timing on CLKCPU.
- Terminates the CPU cycle with 16-bit DSACK1.
- Sits beside the Gayle register block on the same CPU bus; the IDE interrupt it serves feeds that block's IDE_INT input.

Parameters:
- SETUP_CYC, 2, CLKCPU cycles with CS/address valid before the strobe (1..15; 0 treated as 1).
- STROBE_CYC, 4, CLKCPU cycles the RD/WR strobe is held low (1..15; 0 treated as 1).
- HOLD_CYC, 1, CLKCPU cycles after the strobe rises before DSACK1 is asserted (1..15; 0 treated as 1).

Ports:
- CLKCPU  in  1  CPU clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- AS20  in  1  CPU address strobe, active low.
- DS20  in  1  CPU data strobe, active low.
- RW  in  1  1 = read, 0 = write.
- A  in  24  CPU address.
- D_IN  in  16  CPU write data (D31:16).
- D_OUT  out  16  registered read data to the CPU.
- D_OE  out  1  drive D_OUT onto the CPU bus.
- DSACK1  out  1  16-bit port acknowledge, active low.
- ACCESS  out  1  active-low decode hit: A[23:16]=$DA, A[15]=0, A[14:13]=2'b01.
- IDE_CS0  out  1  active low; selected when A[12]=0.
- IDE_CS1  out  1  active low; selected when A[12]=1.
- IDE_A  out  3  drive register address = A[4:2].
- IDE_RD  out  1  DIOR, active low.
- IDE_WR  out  1  DIOW, active low.
- IDE_DIN  in  16  drive data in.
- IDE_DOUT  out  16  data to the drive.
- IDE_DOE  out  1  drive IDE_DOUT onto the IDE bus.

Behaviour:
- Reset (async, RESET low): state IDLE, counter 0; all active-low outputs high; D_OE=0, IDE_DOE=0; D_OUT=0, IDE_DOUT=0, IDE_A=0.
- ACCESS is combinational from A. Everything else is registered.
- States: IDLE, SETUP, STROBE, HOLD, TERM. Counter is 4 bits and loads (param−1) on entry to each timed state.
- IDLE → SETUP when AS20=0 and the decode hits, sampled at a rising edge.
  - On entry, latch IDE_A=A[4:2], the selected CS and the direction.
  - On a write, also latch IDE_DOUT=D_IN and set IDE_DOE=1.
- SETUP: CS low, strobes high. When the counter reaches 0 → STROBE.
- STROBE: IDE_RD low (read) or IDE_WR low (write). When the counter reaches 0 → HOLD.
  - On a read, capture D_OUT=IDE_DIN on that same final edge.
- HOLD: strobes high, CS still low, IDE_DOE still valid. When the counter reaches 0 → TERM.
- TERM: DSACK1 low; CS high, IDE_DOE=0. D_OE=1 on reads once DS20=0.
  - Remains in TERM until AS20=1, then → IDLE with DSACK1 and D_OE released on that edge.
- Latency with defaults, measured from the AS20-sampled edge: strobe low for cycles 3–6, DSACK1 low at cycle 8.
- Abort: AS20 high in SETUP, STROBE or HOLD → IDLE on the next edge. All strobes, CS, IDE_DOE and DSACK1 return inactive; no DSACK is issued.
- A strobe is never shortened by an abort. If AS20 rises during STROBE, the strobe still completes its count, then the block goes directly to IDLE.
- Back-to-back cycles: a new AS20 fall is only accepted from IDLE, which guarantees at least one idle clock between strobes.
- A mid-operation RESET forces all outputs inactive immediately (async).

Optional Feature:
- Macro: IDE_IORDY_EN.
- Defined: adds input IDE_IORDY (1 bit).
  - In STROBE, when the counter is 0 and IDE_IORDY=0, the block remains in STROBE (strobe held low) until IDE_IORDY=1.
  - Read data is captured on the edge leaving STROBE.
  - An abort does not cut the wait short.
- Undefined: no IDE_IORDY port; strobe width is fixed at STROBE_CYC.

Decomposition:
- Package tf_ide_pkg holds:
  - the state enum and its encoding;
  - IDE_BASE ($DA, A[15:13]=3'b001);
  - parameter defaults;
  - the 4-bit counter width.
- Sub-module ide_timer: loadable 4-bit down-counter with a zero flag, reused for all three timed states.

Test Plan:
- Read $DA2004, defaults, IDE_DIN=16'hA55A:
  - IDE_CS0=0, IDE_A=1, IDE_RD low exactly 4 clocks, DSACK1 low 1 clock after IDE_RD rises;
  - D_OUT=16'hA55A with D_OE=1 after DS20 falls;
  - all outputs release the clock after AS20=1.
- Write 16'h00EC to $DA201C:
  - IDE_CS0=0, IDE_A=7, IDE_DOUT=16'h00EC with IDE_DOE=1 from SETUP through HOLD;
  - IDE_WR low 4 clocks; IDE_CS1 stays 1.
- Read $DA3018: IDE_CS1=0, IDE_CS0=1, IDE_A=6, DSACK1 asserted.
- Address $DA0000 or $DE1000: ACCESS=1, no CS, strobe or DSACK1 activity.
- Abort: AS20 rises in SETUP cycle 1 → next edge IDLE, no strobe, DSACK1 never low.
- Assert RESET=0 mid-STROBE:
  - IDE_RD=1 and CS high immediately, no DSACK;
  - after release, a fresh read completes normally.
- With IDE_IORDY_EN: hold IDE_IORDY=0 for 5 extra clocks → IDE_RD low 9 clocks, data captured at the final strobe edge, DSACK1 follows after HOLD.
